// File: rtl/mac_share_arbiter.sv
// mac_share_arbiter: round-robin sharing of one MAC engine between NREQ
// requesters. One operand pair is in flight at a time: accept, issue to the
// engine, wait for the result, then hand it back to the granted requester.
module mac_share_arbiter #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2,
  parameter int IDW   = 3,
  parameter int CNTW  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_x,
  input  logic [NREQ*WIDTH-1:0] req_y,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        grant_id,
  output logic                  mac_input_valid,
  input  logic                  mac_input_ready,
  output logic [WIDTH-1:0]      mac_x,
  output logic [WIDTH-1:0]      mac_y,
  input  logic                  mac_output_valid,
  output logic                  mac_output_ready,
  input  logic [WIDTH-1:0]      mac_result,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [CNTW-1:0]  op_count_q, op_count_d;

  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic [NREQ-1:0]  pick_onehot;
  logic [WIDTH-1:0] pick_x;
  logic [WIDTH-1:0] pick_y;
  logic             gnt_rsp_ready;

  // Round-robin pick: first pass scans rr_ptr..NREQ-1, second pass wraps to
  // 0..rr_ptr-1; together they give the cyclic order from rr_ptr.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    pick_x      = '0;
    pick_y      = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!pick_found && req_valid[i] && (i >= 32'(rr_ptr_q))) begin
        pick_found     = 1'b1;
        pick_idx       = IDW'(i);
        pick_onehot[i] = 1'b1;
        pick_x         = req_x[i*WIDTH +: WIDTH];
        pick_y         = req_y[i*WIDTH +: WIDTH];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!pick_found && req_valid[i]) begin
        pick_found     = 1'b1;
        pick_idx       = IDW'(i);
        pick_onehot[i] = 1'b1;
        pick_x         = req_x[i*WIDTH +: WIDTH];
        pick_y         = req_y[i*WIDTH +: WIDTH];
      end
    end
  end

  // Response routing: only the granted requester sees rsp_valid, and only its
  // rsp_ready is honoured.
  always_comb begin
    rsp_valid     = '0;
    gnt_rsp_ready = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q == IDW'(i)) begin
        rsp_valid[i]  = (state_q == ST_RESP);
        gnt_rsp_ready = rsp_ready[i];
      end
    end
  end

  // req_ready is gated by reset_n so it stays low during reset even though
  // the state register already reads IDLE.
  always_comb begin
    req_ready        = (state_q == ST_IDLE && reset_n) ? pick_onehot : '0;
    mac_input_valid  = (state_q == ST_ISSUE);
    mac_output_ready = (state_q == ST_WAIT);
    mac_x            = x_q;
    mac_y            = y_q;
    busy             = (state_q != ST_IDLE);
    grant_id         = grant_q;
    rsp_data         = rsp_data_q;
    op_count         = op_count_q;
  end

  // Next-state and datapath updates for the four-phase transaction.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    x_d        = x_q;
    y_d        = y_q;
    rsp_data_d = rsp_data_q;
    op_count_d = op_count_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          x_d      = pick_x;
          y_d      = pick_y;
          grant_d  = pick_idx;
          rr_ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mac_input_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mac_output_valid) begin
          rsp_data_d = mac_result;
          state_d    = ST_RESP;
        end
      end
      default: begin
        if (gnt_rsp_ready) begin
          op_count_d = op_count_q + 1'b1;
          state_d    = ST_IDLE;
        end
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rsp_data_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rsp_data_q <= rsp_data_d;
      op_count_q <= op_count_d;
    end
  end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// Directed bench for mac_share_arbiter with a behavioural accumulating MAC.
module tb_mac_share_arbiter;

  localparam int WIDTH = 16;
  localparam int NREQ  = 2;
  localparam int IDW   = 3;
  localparam int CNTW  = 16;

  logic                  clock = 1'b0;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        grant_id;
  logic                  mac_input_valid;
  logic                  mac_input_ready;
  logic [WIDTH-1:0]      mac_x;
  logic [WIDTH-1:0]      mac_y;
  logic                  mac_output_valid;
  logic                  mac_output_ready;
  logic [WIDTH-1:0]      mac_result;
  logic                  busy;
  logic [CNTW-1:0]       op_count;

  int checks = 0;
  int errors = 0;
  logic other_rsp;

  mac_share_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .IDW(IDW), .CNTW(CNTW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .grant_id(grant_id),
    .mac_input_valid(mac_input_valid), .mac_input_ready(mac_input_ready),
    .mac_x(mac_x), .mac_y(mac_y),
    .mac_output_valid(mac_output_valid), .mac_output_ready(mac_output_ready),
    .mac_result(mac_result), .busy(busy), .op_count(op_count)
  );

  always #5 clock = ~clock;

  // Behavioural MAC engine: accumulates x*y, one result pending at a time.
  logic             eng_in_en;
  logic             eng_out_en;
  logic             eng_pend;
  logic [WIDTH-1:0] eng_acc;
  assign mac_input_ready  = eng_in_en && !eng_pend;
  assign mac_output_valid = eng_pend && eng_out_en;
  assign mac_result       = eng_acc;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eng_acc  <= '0;
      eng_pend <= 1'b0;
    end else if (mac_input_valid && mac_input_ready) begin
      eng_acc  <= eng_acc + mac_x * mac_y;
      eng_pend <= 1'b1;
    end else if (mac_output_valid && mac_output_ready) begin
      eng_pend <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
  endtask

  // Bounded wait for any rsp_valid; flags responses to the wrong requester.
  task automatic wait_rsp(input logic [NREQ-1:0] exp_vec, input string tag);
    logic got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (rsp_valid != '0) begin
        got = 1'b1;
        if (rsp_valid != exp_vec) other_rsp = 1'b1;
      end
    end
    chk({tag, "_rsp_seen"}, 32'(got), 1);
    chk({tag, "_rsp_vec"}, 32'(rsp_valid), 32'(exp_vec));
  endtask

  task automatic ack(input logic [NREQ-1:0] vec);
    rsp_ready = vec;
    tick();
    rsp_ready = '0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = '0;
    eng_in_en = 1'b1; eng_out_en = 1'b1; other_rsp = 1'b0;
    do_reset();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_opcount", 32'(op_count), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_rspdata", 32'(rsp_data), 0);

    // 1. Single request from requester 0: 3*4 = 12
    req_valid = 2'b01; req_x[15:0] = 16'd3; req_y[15:0] = 16'd4;
    #1;
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    chk("t1_mac_valid", 32'(mac_input_valid), 1);
    chk("t1_mac_x", 32'(mac_x), 3);
    chk("t1_mac_y", 32'(mac_y), 4);
    chk("t1_busy", 32'(busy), 1);
    wait_rsp(2'b01, "t1");
    chk("t1_data", 32'(rsp_data), 12);
    ack(2'b01);
    chk("t1_opcount", 32'(op_count), 1);
    chk("t1_idle", 32'(busy), 0);
    chk("t1_no_rsp1", 32'(other_rsp), 0);

    // 2. Contention held from reset: grant 0 (2*5=10) then 1 (10+3*3=19)
    reset_n = 1'b0;
    req_valid = 2'b11;
    req_x = {16'd3, 16'd2}; req_y = {16'd3, 16'd5};
    #1;
    chk("t2_ready_in_reset", 32'(req_ready), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    chk("t2_first_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10;
    wait_rsp(2'b01, "t2a");
    chk("t2a_data", 32'(rsp_data), 10);
    chk("t2a_grant", 32'(grant_id), 0);
    ack(2'b01);
    chk("t2_second_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = '0;
    wait_rsp(2'b10, "t2b");
    chk("t2b_data", 32'(rsp_data), 19);
    chk("t2b_grant", 32'(grant_id), 1);
    ack(2'b10);

    // 3. Fairness: both valid, x=y=1, six transactions alternate 0,1,...
    do_reset();
    req_valid = 2'b11; req_x = {16'd1, 16'd1}; req_y = {16'd1, 16'd1};
    for (int n = 0; n < 6; n++) begin
      logic [NREQ-1:0] exp_vec;
      exp_vec = (n % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      chk("t3_ready", 32'(req_ready), 32'(exp_vec));
      tick();
      wait_rsp(exp_vec, "t3");
      chk("t3_grant", 32'(grant_id), 32'(n % 2));
      chk("t3_data", 32'(rsp_data), 32'(n + 1));
      ack(exp_vec);
    end
    chk("t3_opcount", 32'(op_count), 6);
    req_valid = '0;

    // 4. Backpressure on requester 1 (5*6=30); rsp_ready[0] toggling is ignored
    do_reset();
    req_valid = 2'b10; req_x = {16'd5, 16'd1}; req_y = {16'd6, 16'd1};
    #1;
    chk("t4_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b11;
    wait_rsp(2'b10, "t4");
    for (int c = 0; c < 5; c++) begin
      rsp_ready = (c % 2 == 0) ? 2'b01 : 2'b00;
      #1;
      chk("t4_hold_valid", 32'(rsp_valid), 32'h2);
      chk("t4_hold_data", 32'(rsp_data), 30);
      chk("t4_no_req_ready", 32'(req_ready), 0);
      tick();
    end
    chk("t4_still_resp", 32'(rsp_valid), 32'h2);
    ack(2'b10);
    chk("t4_opcount", 32'(op_count), 1);
    chk("t4_next_ready", 32'(req_ready), 32'h1);
    req_valid = '0;

    // 5. Engine stall: mac_input_ready low for 3 cycles, 7*8=56
    do_reset();
    eng_in_en = 1'b0;
    req_valid = 2'b01; req_x = {16'd0, 16'd7}; req_y = {16'd0, 16'd8};
    tick();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      chk("t5_stall_valid", 32'(mac_input_valid), 1);
      chk("t5_stall_x", 32'(mac_x), 7);
      chk("t5_stall_y", 32'(mac_y), 8);
      if (c < 2) tick();
    end
    eng_in_en = 1'b1;
    wait_rsp(2'b01, "t5");
    chk("t5_data", 32'(rsp_data), 56);
    ack(2'b01);

    // 6. Asynchronous reset while in WAIT for requester 1
    eng_out_en = 1'b0;
    req_valid = 2'b10; req_x = {16'd2, 16'd0}; req_y = {16'd3, 16'd0};
    tick();
    req_valid = '0;
    tick();
    chk("t6_in_wait", 32'(mac_output_ready), 1);
    chk("t6_grant_pre", 32'(grant_id), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_out_ready", 32'(mac_output_ready), 0);
    chk("t6_in_valid", 32'(mac_input_valid), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0);
    chk("t6_req_ready", 32'(req_ready), 0);
    chk("t6_grant", 32'(grant_id), 0);
    chk("t6_rspdata", 32'(rsp_data), 0);
    chk("t6_opcount", 32'(op_count), 0);
    chk("t6_mac_x", 32'(mac_x), 0);
    eng_out_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    #1;
    req_valid = 2'b01; req_x = {16'd0, 16'd4}; req_y = {16'd0, 16'd5};
    tick();
    req_valid = '0;
    wait_rsp(2'b01, "t6");
    chk("t6_data", 32'(rsp_data), 20);
    ack(2'b01);
    chk("t6_opcount_after", 32'(op_count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
